msg_stream_serializer: RTL

MSG_STREAM_SERIALIZER -- requirements
Module: msg_stream_serializer

---
 rtl/msg_stream_serializer.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/msg_stream_serializer.sv
// Serialises 128-bit message words from a standard FIFO into 32-bit beats, MSB word first,
// with start-of-frame marking, one-word prefetch for gap-free streaming, and beat/frame counters.
module msg_stream_serializer #(
  parameter logic [31:0] HEADER = 32'hFDF7_EB90
) (
  input  logic         sys_clk_i,
  input  logic         rst_i,
  output logic         us_rd_clk_o,
  output logic         us_rd_en_o,
  input  logic [127:0] us_din_i,
  input  logic         us_empty_i,
  output logic         tx_valid_o,
  output logic [31:0]  tx_data_o,
  output logic         tx_sof_o,
  input  logic         tx_ready_i,
  output logic [15:0]  frame_cnt_o,
  output logic [31:0]  beat_cnt_o
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  state_t         state_r, state_n;
  logic [127:0]   shift_r, shift_n;
  logic [1:0]     idx_r, idx_n;
  logic           sof_r, sof_n;
  logic [127:0]   pf_r, pf_n;
  logic           pf_full_r, pf_full_n;
  logic           rd_en_r, rd_en_n;
  logic           cap_r;
  logic [15:0]    frame_r, frame_n;
  logic [31:0]    beat_r, beat_n;
  logic           accept_s;
  logic           load_s;

  function automatic logic is_header(input logic [127:0] word);
    return (word[127:96] == HEADER);
  endfunction

  assign us_rd_clk_o = sys_clk_i;
  assign us_rd_en_o  = rd_en_r;
  assign tx_valid_o  = (state_r == S_SEND);
  assign tx_data_o   = shift_r[127:96];
  assign tx_sof_o    = sof_r;
  assign frame_cnt_o = frame_r;
  assign beat_cnt_o  = beat_r;

  // Next-state logic: FSM, beat shifting, prefetch bookkeeping, FIFO read request and counters
  always_comb begin
    state_n   = state_r;
    shift_n   = shift_r;
    idx_n     = idx_r;
    sof_n     = sof_r;
    pf_n      = pf_r;
    pf_full_n = pf_full_r;
    frame_n   = frame_r;
    beat_n    = beat_r;
    load_s    = 1'b0;
    accept_s  = (state_r == S_SEND) && tx_ready_i;

    case (state_r)
      S_IDLE: begin
        if (pf_full_r) begin
          load_s  = 1'b1;
          state_n = S_SEND;
        end else begin
          state_n = S_IDLE;
        end
      end
      S_SEND: begin
        if (accept_s && (idx_r == 2'd3)) begin
          if (pf_full_r) begin
            load_s = 1'b1;
          end else begin
            state_n = S_IDLE;
            shift_n = {shift_r[95:0], 32'h0000_0000};
            idx_n   = 2'd0;
            sof_n   = 1'b0;
          end
        end else if (accept_s) begin
          shift_n = {shift_r[95:0], 32'h0000_0000};
          idx_n   = idx_r + 2'd1;
          sof_n   = 1'b0;
        end else begin
          state_n = S_SEND;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    // Loading consumes the old prefetch value; a read returning in the same cycle refills it
    if (load_s) begin
      shift_n   = pf_r;
      idx_n     = 2'd0;
      sof_n     = is_header(pf_r);
      pf_full_n = 1'b0;
    end else begin
      pf_full_n = pf_full_r;
    end

    if (cap_r) begin
      pf_n      = us_din_i;
      pf_full_n = 1'b1;
    end else begin
      pf_n = pf_r;
    end

    if (accept_s) begin
      beat_n = beat_r + 32'd1;
      if (sof_r) begin
        frame_n = frame_r + 16'd1;
      end else begin
        frame_n = frame_r;
      end
    end else begin
      beat_n  = beat_r;
      frame_n = frame_r;
    end

    rd_en_n = !us_empty_i && !pf_full_r && !rd_en_r && !cap_r;
  end

  // State and datapath registers with asynchronous reset
  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r   <= S_IDLE;
      shift_r   <= 128'd0;
      idx_r     <= 2'd0;
      sof_r     <= 1'b0;
      pf_r      <= 128'd0;
      pf_full_r <= 1'b0;
      rd_en_r   <= 1'b0;
      cap_r     <= 1'b0;
      frame_r   <= 16'd0;
      beat_r    <= 32'd0;
    end else begin
      state_r   <= state_n;
      shift_r   <= shift_n;
      idx_r     <= idx_n;
      sof_r     <= sof_n;
      pf_r      <= pf_n;
      pf_full_r <= pf_full_n;
      rd_en_r   <= rd_en_n;
      cap_r     <= rd_en_r;
      frame_r   <= frame_n;
      beat_r    <= beat_n;
    end
  end

endmodule
